// File: rtl/bp_fe_mem_tracker.sv
// rtl/bp_fe_mem_tracker.sv - fetch-side memory tracker between PC generator and I-TLB/I-cache
module bp_fe_mem_tracker #(
  parameter int vaddr_width_p       = 39,
  parameter int ptag_width_p        = 28,
  parameter int page_offset_width_p = 12,
  parameter int fetch_width_p       = 32,
  parameter int resp_els_p          = 4,
  parameter int did_width_p         = 3,
  parameter int dram_base_ptag_p    = 'h80000
) (
  input  logic                               clk_i,
  input  logic                               reset_i,

  // Command port from the PC generator
  input  logic                               cmd_v_i,
  input  logic [1:0]                         cmd_op_i,
  input  logic [vaddr_width_p-1:0]           cmd_vaddr_i,
  output logic                               cmd_yumi_o,

  // Selective kill of in-flight stages
  input  logic                               poison_s1_i,
  input  logic                               poison_s2_i,

  // Execution context
  input  logic [1:0]                         priv_i,
  input  logic                               translation_en_i,
  input  logic                               uncached_mode_i,

  // I-TLB interface
  output logic                               tlb_v_o,
  output logic                               tlb_w_o,
  output logic                               tlb_flush_o,
  input  logic                               tlb_v_i,
  input  logic                               tlb_miss_i,
  input  logic [ptag_width_p-1:0]            tlb_ptag_i,
  input  logic                               tlb_u_i,
  input  logic                               tlb_x_i,
  input  logic                               uncached_i,

  // I-cache interface
  output logic                               icache_v_o,
  input  logic                               icache_ready_i,
  output logic                               icache_poison_o,
  input  logic [fetch_width_p-1:0]           icache_data_i,
  input  logic                               icache_data_v_i,

  // Response queue head
  output logic                               resp_v_o,
  input  logic                               resp_ready_i,
  output logic [fetch_width_p-1:0]           resp_data_o,
  output logic [3:0]                         resp_flags_o,
  output logic [$clog2(resp_els_p+1)-1:0]    credits_o
);

  localparam int ptr_width_lp = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
  localparam int cnt_width_lp = $clog2(resp_els_p + 1);
  localparam int vpn_width_lp = vaddr_width_p - page_offset_width_p;

  localparam logic [ptag_width_p-1:0] dram_base_ptag_lp = ptag_width_p'(dram_base_ptag_p);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp       = ptr_width_lp'(resp_els_p - 1);
  localparam logic [cnt_width_lp-1:0] full_cnt_lp       = cnt_width_lp'(resp_els_p);

  // The fetch address is routed to the TLB/I-cache outside this block; the
  // tracker itself only sequences the lookup, so the address is not consumed.
  logic [vpn_width_lp-1:0]        unused_vpn;
  logic [page_offset_width_p-1:0] unused_offset;
  logic                           unused_ok;
  assign unused_vpn    = cmd_vaddr_i[vaddr_width_p-1 -: vpn_width_lp];
  assign unused_offset = cmd_vaddr_i[page_offset_width_p-1:0];
  assign unused_ok     = ^{unused_vpn, unused_offset};

  // -------------------------------------------------------------------------
  // Pipeline and queue state
  // -------------------------------------------------------------------------
  logic                     s1_v;
  logic                     s2_v;
  logic                     s2_access_fault;
  logic                     s2_page_fault;
  logic                     s2_itlb_miss;

  logic [fetch_width_p-1:0] data_mem  [resp_els_p];
  logic [3:0]               flags_mem [resp_els_p];
  logic [ptr_width_lp-1:0]  wr_ptr;
  logic [ptr_width_lp-1:0]  rd_ptr;
  logic [cnt_width_lp-1:0]  count;

  // -------------------------------------------------------------------------
  // Command decode and acceptance
  // -------------------------------------------------------------------------
  logic is_fetch_op;
  logic fill;
  logic fence;
  logic fetch_accept;

  // Reserved opcode 3 is handled as an ordinary fetch.
  assign is_fetch_op  = (cmd_op_i == 2'd0) | (cmd_op_i == 2'd3);
  assign fill         = cmd_v_i & (cmd_op_i == 2'd1);
  assign fence        = cmd_v_i & (cmd_op_i == 2'd2);

  // A fetch needs the cache and a guaranteed landing slot in the queue.
  assign fetch_accept = cmd_v_i & is_fetch_op & icache_ready_i & (credits_o != '0);

  assign cmd_yumi_o   = fill | fence | fetch_accept;
  assign tlb_v_o      = fetch_accept | fill;
  assign tlb_w_o      = fill;
  assign tlb_flush_o  = fence;
  assign icache_v_o   = fetch_accept;

  // Every in-flight fetch holds a reservation until it enqueues or dies.
  assign credits_o = full_cnt_lp - count
                   - cnt_width_lp'(s1_v)
                   - cnt_width_lp'(s2_v);

  // -------------------------------------------------------------------------
  // Stage 1: translation result checks
  // -------------------------------------------------------------------------
  logic [did_width_p-1:0] s1_did;
  logic                   mode_fault;
  logic                   did_fault;
  logic                   local_fault;
  logic                   priv_s;
  logic                   priv_u;
  logic                   s1_access_fault;
  logic                   s1_page_fault;
  logic                   s1_itlb_miss;

  assign s1_did      = tlb_ptag_i[ptag_width_p-1 -: did_width_p];
  // In uncached mode only PMA-uncached regions may be fetched from.
  assign mode_fault  = uncached_mode_i & ~uncached_i;
  assign did_fault   = |s1_did;
  assign local_fault = tlb_ptag_i < dram_base_ptag_lp;

  assign priv_s      = (priv_i == 2'd1);
  assign priv_u      = (priv_i == 2'd0);

  assign s1_access_fault = s1_v & (mode_fault | did_fault | local_fault);
  // S-mode may not execute user pages; U-mode may only execute user pages.
  assign s1_page_fault   = s1_v & tlb_v_i & translation_en_i
                         & (~tlb_x_i | (priv_s & tlb_u_i) | (priv_u & ~tlb_u_i));
  assign s1_itlb_miss    = s1_v & tlb_miss_i;

  // Cancel the cache access for anything that will not return usable data.
  assign icache_poison_o = s1_v & (poison_s1_i | s1_access_fault | s1_page_fault | tlb_miss_i);

  // Advance the two lookup stages and register stage-1 faults into stage 2.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v            <= 1'b0;
      s2_v            <= 1'b0;
      s2_access_fault <= 1'b0;
      s2_page_fault   <= 1'b0;
      s2_itlb_miss    <= 1'b0;
    end else begin
      s1_v            <= fetch_accept;
      s2_v            <= s1_v & ~poison_s1_i;
      s2_access_fault <= s1_access_fault;
      s2_page_fault   <= s1_page_fault;
      s2_itlb_miss    <= s1_itlb_miss;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: data capture and enqueue
  // -------------------------------------------------------------------------
  logic       s2_any_fault;
  logic       s2_icache_miss;
  logic       enq;
  logic       deq;
  logic [3:0] enq_flags;

  assign s2_any_fault   = s2_access_fault | s2_page_fault | s2_itlb_miss;
  // A cache miss is only reported when no earlier fault explains the missing data.
  assign s2_icache_miss = ~icache_data_v_i & ~s2_any_fault;
  assign enq_flags      = {s2_access_fault, s2_page_fault, s2_itlb_miss, s2_icache_miss};
  assign enq            = s2_v & ~poison_s2_i;
  assign deq            = resp_v_o & resp_ready_i;

  function automatic logic [ptr_width_lp-1:0] ptr_next(input logic [ptr_width_lp-1:0] p);
    // Explicit wrap so non-power-of-two depths index correctly.
    return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
  endfunction

  // Queue storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      data_mem[wr_ptr]  <= icache_data_i;
      flags_mem[wr_ptr] <= enq_flags;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_next(wr_ptr);
      if (deq) rd_ptr <= ptr_next(rd_ptr);
      case ({enq, deq})
        2'b10:   count <= count + cnt_width_lp'(1);
        2'b01:   count <= count - cnt_width_lp'(1);
        default: count <= count;
      endcase
    end
  end

  // Head of queue; data and flags are zeroed when nothing is valid.
  assign resp_v_o     = (count != '0);
  assign resp_data_o  = resp_v_o ? data_mem[rd_ptr]  : '0;
  assign resp_flags_o = resp_v_o ? flags_mem[rd_ptr] : '0;

  // Credits reserve a slot per in-flight fetch, so a full queue never
  // receives an enqueue without a matching dequeue.
  assert property (@(posedge clk_i) disable iff (reset_i)
                   !(enq && (count == full_cnt_lp) && !deq));

endmodule

// File: tb/tb_bp_fe_mem_tracker.sv
// tb/tb_bp_fe_mem_tracker.sv - directed bench for bp_fe_mem_tracker
module tb_bp_fe_mem_tracker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cmd_v;
  logic [1:0]  cmd_op;
  logic [38:0] cmd_vaddr;
  logic        poison_s1, poison_s2;
  logic [1:0]  priv;
  logic        translation_en, uncached_mode;
  logic        tlb_v_in, tlb_miss, tlb_u, tlb_x, uncached;
  logic [27:0] tlb_ptag;
  logic        icache_ready, icache_data_v, resp_ready;
  logic [31:0] icache_data;

  logic        yumi, tlb_v_out, tlb_w, tlb_flush, icache_v, icache_poison, resp_v;
  logic [31:0] resp_data;
  logic [3:0]  resp_flags;
  logic [2:0]  credits;

  logic        b_yumi, b_tlb_v_out, b_tlb_w, b_tlb_flush, b_icache_v, b_icache_poison, b_resp_v;
  logic [31:0] b_resp_data;
  logic [3:0]  b_resp_flags;
  logic [1:0]  b_credits;

  bp_fe_mem_tracker dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_v_i(cmd_v), .cmd_op_i(cmd_op), .cmd_vaddr_i(cmd_vaddr), .cmd_yumi_o(yumi),
    .poison_s1_i(poison_s1), .poison_s2_i(poison_s2),
    .priv_i(priv), .translation_en_i(translation_en), .uncached_mode_i(uncached_mode),
    .tlb_v_o(tlb_v_out), .tlb_w_o(tlb_w), .tlb_flush_o(tlb_flush),
    .tlb_v_i(tlb_v_in), .tlb_miss_i(tlb_miss), .tlb_ptag_i(tlb_ptag),
    .tlb_u_i(tlb_u), .tlb_x_i(tlb_x), .uncached_i(uncached),
    .icache_v_o(icache_v), .icache_ready_i(icache_ready), .icache_poison_o(icache_poison),
    .icache_data_i(icache_data), .icache_data_v_i(icache_data_v),
    .resp_v_o(resp_v), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .resp_flags_o(resp_flags), .credits_o(credits)
  );

  bp_fe_mem_tracker #(.resp_els_p(3)) dut3 (
    .clk_i(clk), .reset_i(reset),
    .cmd_v_i(cmd_v), .cmd_op_i(cmd_op), .cmd_vaddr_i(cmd_vaddr), .cmd_yumi_o(b_yumi),
    .poison_s1_i(poison_s1), .poison_s2_i(poison_s2),
    .priv_i(priv), .translation_en_i(translation_en), .uncached_mode_i(uncached_mode),
    .tlb_v_o(b_tlb_v_out), .tlb_w_o(b_tlb_w), .tlb_flush_o(b_tlb_flush),
    .tlb_v_i(tlb_v_in), .tlb_miss_i(tlb_miss), .tlb_ptag_i(tlb_ptag),
    .tlb_u_i(tlb_u), .tlb_x_i(tlb_x), .uncached_i(uncached),
    .icache_v_o(b_icache_v), .icache_ready_i(icache_ready), .icache_poison_o(b_icache_poison),
    .icache_data_i(icache_data), .icache_data_v_i(icache_data_v),
    .resp_v_o(b_resp_v), .resp_ready_i(resp_ready), .resp_data_o(b_resp_data),
    .resp_flags_o(b_resp_flags), .credits_o(b_credits)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc_n  = 0;
  bit          auto_data = 1'b1;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  priv;
    logic        tr, um, unc, tv, miss;
    logic [27:0] ptag;
    logic        u, x;
    logic [31:0] data;
    logic        dv;
    logic [3:0]  flags;
    logic        poison;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int c);
    return 32'hC0DE0000 | 32'(c + 2);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc_n++;
    if (auto_data) icache_data = 32'hC0DE0000 | 32'(cyc_n);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_defaults();
    priv = 2'd3; translation_en = 0; uncached_mode = 0; uncached = 0;
    tlb_v_in = 1; tlb_miss = 0; tlb_ptag = 28'h0080000; tlb_u = 0; tlb_x = 0;
    icache_data_v = 1;
  endtask

  task automatic release_reset();
    reset = 0; cyc_n = 0; icache_data = 32'hC0DE0000; exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1; cmd_v = 0; cmd_op = 0; poison_s1 = 0; poison_s2 = 0;
    resp_ready = 0; icache_ready = 1; auto_data = 1; set_defaults();
    repeat (2) @(posedge clk);
    #1;
    release_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op    priv  tr    um    unc   tv    miss  ptag          u     x     data          dv    flags    poison
    vecs[0]  = '{2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0080000, 1'b0, 1'b0, 32'h00000013, 1'b1, 4'b0000, 1'b0};
    vecs[1]  = '{2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0000010, 1'b0, 1'b0, 32'h00100093, 1'b1, 4'b1000, 1'b1};
    vecs[2]  = '{2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0080000, 1'b1, 1'b1, 32'h00200113, 1'b1, 4'b0100, 1'b1};
    vecs[3]  = '{2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0080000, 1'b0, 1'b1, 32'h00300193, 1'b1, 4'b0100, 1'b1};
    vecs[4]  = '{2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0080000, 1'b1, 1'b1, 32'h00400213, 1'b1, 4'b0000, 1'b0};
    vecs[5]  = '{2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0080000, 1'b0, 1'b0, 32'h00500293, 1'b1, 4'b0100, 1'b1};
    vecs[6]  = '{2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0080000, 1'b0, 1'b1, 32'h00600313, 1'b1, 4'b0000, 1'b0};
    vecs[7]  = '{2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0080000, 1'b0, 1'b0, 32'h00700393, 1'b1, 4'b0010, 1'b1};
    vecs[8]  = '{2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0080000, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 4'b0001, 1'b0};
    vecs[9]  = '{2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0000010, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 4'b1000, 1'b1};
    vecs[10] = '{2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 28'h2080000, 1'b0, 1'b0, 32'h01000013, 1'b1, 4'b1000, 1'b1};
    vecs[11] = '{2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 28'h0080000, 1'b0, 1'b0, 32'h01100013, 1'b1, 4'b1000, 1'b1};
    vecs[12] = '{2'd0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 28'h0080000, 1'b0, 1'b0, 32'h01200013, 1'b1, 4'b0000, 1'b0};
    vecs[13] = '{2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0080000, 1'b0, 1'b0, 32'h01300013, 1'b1, 4'b0000, 1'b0};
    vecs[14] = '{2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 28'h007FFFF, 1'b0, 1'b0, 32'h01400013, 1'b1, 4'b1000, 1'b1};
    vecs[15] = '{2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0000010, 1'b0, 1'b0, 32'h01500013, 1'b1, 4'b1100, 1'b1};
    vecs[16] = '{2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0080000, 1'b0, 1'b0, 32'h01600013, 1'b1, 4'b0010, 1'b1};

    reset = 1; cmd_v = 0; cmd_op = 0; cmd_vaddr = 39'h0080000000;
    poison_s1 = 0; poison_s2 = 0; resp_ready = 0; icache_ready = 1; icache_data = 0;
    set_defaults();

    // Reset state
    sample();
    chk("rst_resp_v", resp_v, 0);
    chk("rst_credits", credits, 4);
    chk("rst_credits_d3", b_credits, 3);
    chk("rst_yumi", yumi, 0);
    chk("rst_tlb_v", tlb_v_out, 0);
    chk("rst_icache_v", icache_v, 0);
    chk("rst_icache_poison", icache_poison, 0);
    chk("rst_flags", resp_flags, 0);
    chk("rst_data", resp_data, 0);

    // Single-fetch vectors
    do_reset();
    auto_data = 0;
    for (int i = 0; i < 17; i++) begin
      cmd_op = vecs[i].op; priv = vecs[i].priv; translation_en = vecs[i].tr;
      uncached_mode = vecs[i].um; uncached = vecs[i].unc; tlb_v_in = vecs[i].tv;
      tlb_miss = vecs[i].miss; tlb_ptag = vecs[i].ptag; tlb_u = vecs[i].u; tlb_x = vecs[i].x;
      icache_data = vecs[i].data; icache_data_v = vecs[i].dv; cmd_v = 1;
      sample();
      chk($sformatf("v%0d_yumi", i), yumi, 1);
      chk($sformatf("v%0d_icache_v", i), icache_v, 1);
      chk($sformatf("v%0d_tlb_v", i), tlb_v_out, 1);
      next_cycle(); cmd_v = 0;
      sample();
      chk($sformatf("v%0d_poison", i), icache_poison, vecs[i].poison);
      chk($sformatf("v%0d_credits_s1", i), credits, 3);
      next_cycle(); sample();
      chk($sformatf("v%0d_resp_v_c2", i), resp_v, 0);
      next_cycle(); sample();
      chk($sformatf("v%0d_resp_v_c3", i), resp_v, 1);
      chk($sformatf("v%0d_data", i), resp_data, vecs[i].data);
      chk($sformatf("v%0d_flags", i), resp_flags, vecs[i].flags);
      resp_ready = 1;
      next_cycle(); resp_ready = 0;
      sample();
      chk($sformatf("v%0d_resp_v_drained", i), resp_v, 0);
      chk($sformatf("v%0d_credits_back", i), credits, 4);
      next_cycle();
    end

    // Backpressure: credits run out, fill still consumed, order preserved
    do_reset();
    for (int c = 0; c < 7; c++) begin
      cmd_v = 1; cmd_op = (c == 6) ? 2'd1 : 2'd0;
      if (c < 4) exp_q.push_back(exp_data(cyc_n));
      sample();
      chk($sformatf("bp_credits_c%0d", c), credits, (c < 4) ? 4 - c : 0);
      chk($sformatf("bp_yumi_c%0d", c), yumi, (c < 4 || c == 6));
      if (c == 6) chk("bp_fill_tlb_w", tlb_w, 1);
      next_cycle();
    end
    cmd_v = 0; cmd_op = 0;
    for (int k = 0; k < 4; k++) begin
      resp_ready = 1;
      sample();
      chk($sformatf("bp_resp_v_%0d", k), resp_v, 1);
      chk($sformatf("bp_order_%0d", k), resp_data, exp_q.pop_front());
      next_cycle();
    end
    resp_ready = 0;
    sample();
    chk("bp_empty", resp_v, 0);
    chk("bp_credits_back", credits, 4);
    next_cycle();

    // Poison in stage 1
    do_reset();
    cmd_v = 1; sample(); chk("ps1_yumi", yumi, 1);
    next_cycle(); cmd_v = 0; poison_s1 = 1;
    sample(); chk("ps1_icache_poison", icache_poison, 1); chk("ps1_credits_s1", credits, 3);
    next_cycle(); poison_s1 = 0;
    sample(); chk("ps1_credit_return", credits, 4); chk("ps1_resp_v_c2", resp_v, 0);
    next_cycle(); sample(); chk("ps1_resp_v_c3", resp_v, 0);
    next_cycle();

    // Poison in stage 2, with a new fetch accepted in the same cycle
    do_reset();
    cmd_v = 1; sample();
    next_cycle(); cmd_v = 0;
    sample(); chk("ps2_icache_poison_clean", icache_poison, 0);
    next_cycle(); poison_s2 = 1; cmd_v = 1; exp_q.push_back(exp_data(cyc_n));
    sample(); chk("ps2_yumi_same_cycle", yumi, 1); chk("ps2_credits_c2", credits, 3);
    next_cycle(); poison_s2 = 0; cmd_v = 0;
    sample(); chk("ps2_credits_c3", credits, 3); chk("ps2_no_resp_c3", resp_v, 0);
    next_cycle(); sample(); chk("ps2_no_resp_c4", resp_v, 0);
    next_cycle(); sample();
    chk("ps2_new_resp_v", resp_v, 1);
    chk("ps2_new_resp_data", resp_data, exp_q.pop_front());
    chk("ps2_credits_c5", credits, 3);
    resp_ready = 1; next_cycle(); resp_ready = 0;
    sample(); chk("ps2_drained", resp_v, 0); chk("ps2_credits_back", credits, 4);
    next_cycle();

    // Fill, fence, cache-not-ready; fence leaves an in-flight fetch alone
    do_reset();
    cmd_v = 1; cmd_op = 2'd1;
    sample();
    chk("fill_yumi", yumi, 1); chk("fill_tlb_v", tlb_v_out, 1); chk("fill_tlb_w", tlb_w, 1);
    chk("fill_flush", tlb_flush, 0); chk("fill_icache_v", icache_v, 0);
    next_cycle(); cmd_op = 2'd2;
    sample();
    chk("fence_yumi", yumi, 1); chk("fence_flush", tlb_flush, 1); chk("fence_tlb_v", tlb_v_out, 0);
    chk("fence_tlb_w", tlb_w, 0); chk("fence_credits", credits, 4);
    next_cycle(); cmd_op = 2'd0; icache_ready = 0;
    sample();
    chk("nrdy_yumi", yumi, 0); chk("nrdy_icache_v", icache_v, 0); chk("nrdy_tlb_v", tlb_v_out, 0);
    next_cycle(); icache_ready = 1; exp_q.push_back(exp_data(cyc_n));
    sample(); chk("ff_fetch_yumi", yumi, 1);
    next_cycle(); cmd_op = 2'd2;
    sample(); chk("ff_fence_yumi", yumi, 1); chk("ff_fence_flush", tlb_flush, 1);
    next_cycle(); cmd_v = 0; cmd_op = 2'd0;
    sample();
    next_cycle(); sample();
    chk("ff_resp_v", resp_v, 1);
    chk("ff_resp_data", resp_data, exp_q.pop_front());
    chk("ff_resp_flags", resp_flags, 0);
    resp_ready = 1; next_cycle(); resp_ready = 0;
    sample(); chk("ff_credits_back", credits, 4);
    next_cycle();

    // Depth-3 queue: fill, partial drain, refill across the pointer wrap
    do_reset();
    cmd_v = 1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) exp_q.push_back(exp_data(cyc_n));
      sample();
      chk($sformatf("d3_yumi_%0d", k), b_yumi, (k < 3));
      chk($sformatf("d3_credits_%0d", k), b_credits, 3 - k);
      next_cycle();
    end
    cmd_v = 0;
    sample(); next_cycle();
    sample();
    chk("d3_full_credits", b_credits, 0);
    chk("d3_full_resp_v", b_resp_v, 1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d3_drain_v_%0d", k), b_resp_v, 1);
      chk($sformatf("d3_drain_data_%0d", k), b_resp_data, exp_q.pop_front());
      resp_ready = 1; next_cycle(); resp_ready = 0;
      sample();
    end
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      cmd_v = 1; exp_q.push_back(exp_data(cyc_n));
      sample();
      chk($sformatf("d3_refill_yumi_%0d", k), b_yumi, 1);
      chk($sformatf("d3_refill_credits_%0d", k), b_credits, 2 - k);
      next_cycle();
    end
    cmd_v = 0;
    sample(); next_cycle();
    sample(); next_cycle();
    sample();
    chk("d3_refull_credits", b_credits, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d3_wrap_v_%0d", k), b_resp_v, 1);
      chk($sformatf("d3_wrap_data_%0d", k), b_resp_data, exp_q.pop_front());
      resp_ready = 1; next_cycle();
      sample();
    end
    resp_ready = 0;
    chk("d3_empty", b_resp_v, 0);
    chk("d3_credits_back", b_credits, 3);
    next_cycle();

    // Asynchronous reset with two queued responses and one in flight
    do_reset();
    cmd_v = 1;
    for (int k = 0; k < 3; k++) begin
      sample(); next_cycle();
    end
    cmd_v = 0;
    sample(); next_cycle();
    sample();
    chk("mr_pre_resp_v", resp_v, 1);
    chk("mr_pre_credits", credits, 1);
    reset = 1;
    #1;
    chk("mr_async_resp_v", resp_v, 0);
    chk("mr_async_credits", credits, 4);
    chk("mr_async_flags", resp_flags, 0);
    @(posedge clk); #1;
    chk("mr_hold_resp_v", resp_v, 0);
    release_reset();
    cmd_v = 1; exp_q.push_back(exp_data(cyc_n));
    sample(); chk("mr_first_yumi", yumi, 1); chk("mr_first_credits", credits, 4);
    next_cycle(); cmd_v = 0;
    sample(); chk("mr_credits_s1", credits, 3);
    next_cycle(); sample(); chk("mr_resp_v_c2", resp_v, 0);
    next_cycle(); sample();
    chk("mr_resp_v_c3", resp_v, 1);
    chk("mr_resp_data", resp_data, exp_q.pop_front());
    resp_ready = 1; next_cycle(); resp_ready = 0;
    sample();
    chk("mr_no_stale", resp_v, 0);
    chk("mr_credits_back", credits, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_fe_mem_tracker.md
Name: bp_fe_mem_tracker

Overview:
- Fetch-side memory tracker between the front-end PC generator and the I-TLB/I-cache.
- Accepts fetch, TLB-fill and TLB-fence commands and runs fetches down a fixed 2-stage lookup pipeline.
- Computes access and page faults, and enqueues each surviving response into a credit-protected response FIFO.
- Unlike the previous FE memory stage, it supports consumer backpressure, configurable fetch width and queue depth, and selective poisoning of in-flight stages.

Parameters:
- vaddr_width_p, 39, virtual address width.
- ptag_width_p, 28, physical tag width.
- page_offset_width_p, 12, page offset bits.
- fetch_width_p, 32, instruction data bits per response (32 or 64).
- resp_els_p, 4, response FIFO depth; must be ≥2.
- did_width_p, 3, domain-ID bits at the top of the ptag.
- dram_base_ptag_p, 'h80000, lowest cacheable ptag; fetches below it fault.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- cmd_v_i  in  1  command valid
- cmd_op_i  in  2  0=fetch, 1=tlb_fill, 2=tlb_fence, 3=reserved (treated as fetch)
- cmd_vaddr_i  in  vaddr_width_p  fetch address
- cmd_yumi_o  out  1  command consumed this cycle
- poison_s1_i  in  1  kill the stage-1 fetch
- poison_s2_i  in  1  kill the stage-2 fetch
- priv_i  in  2  privilege mode (0=U, 1=S, 3=M)
- translation_en_i  in  1  translation enabled
- uncached_mode_i  in  1  I-cache in uncached mode
- tlb_v_o  out  1  TLB lookup/write strobe
- tlb_w_o  out  1  TLB write (fill)
- tlb_flush_o  out  1  TLB fence
- tlb_v_i  in  1  stage-1 translation valid
- tlb_miss_i  in  1  stage-1 TLB miss
- tlb_ptag_i  in  ptag_width_p  stage-1 ptag
- tlb_u_i  in  1  stage-1 user permission
- tlb_x_i  in  1  stage-1 execute permission
- uncached_i  in  1  stage-1 PMA uncached
- icache_v_o  out  1  I-cache lookup strobe
- icache_ready_i  in  1  I-cache can accept a lookup
- icache_poison_o  out  1  cancel the stage-1 I-cache access
- icache_data_i  in  fetch_width_p  stage-2 data
- icache_data_v_i  in  1  stage-2 data hit
- resp_v_o  out  1  response valid (FIFO head)
- resp_ready_i  in  1  consumer ready
- resp_data_o  out  fetch_width_p  instruction data
- resp_flags_o  out  4  {access_fault, page_fault, itlb_miss, icache_miss}
- credits_o  out  clog2(resp_els_p+1)  free FIFO slots not reserved by in-flight fetches

Behaviour:
- Reset: async assert clears s1_v, s2_v, s2 flags, FIFO pointers and count. All outputs read 0 except credits_o=resp_els_p.
- Credits: credits_o = resp_els_p − fifo_count − s1_v − s2_v.
- Fetch accept: cmd_v_i & op==fetch & icache_ready_i & credits_o≠0.
- Fill and fence accept: cmd_v_i only; they are always consumed.
- cmd_yumi_o = fill | fence | fetch accept.
- TLB strobes:
  - tlb_v_o = fetch accept | fill.
  - tlb_w_o = fill.
  - tlb_flush_o = fence.
  - icache_v_o = fetch accept.
- Pipeline:
  - Stage 0 is the accept cycle.
  - s1_v <= fetch accept.
  - s2_v <= s1_v & ~poison_s1_i.
  - Enqueue = s2_v & ~poison_s2_i, giving 2-cycle accept-to-enqueue latency.
  - Response is visible on resp_v_o the cycle after enqueue; there is no bypass.
- Stage-1 faults, registered into stage 2:
  - access_fault = mode_fault | did_fault | local_fault, where:
    - mode_fault = uncached_mode_i & ~uncached_i.
    - did_fault = top did_width_p ptag bits ≠ 0.
    - local_fault = ptag < dram_base_ptag_p.
  - page_fault = tlb_v_i & translation_en_i & (~tlb_x_i | (priv==S & tlb_u_i) | (priv==U & ~tlb_u_i)).
  - itlb_miss = tlb_miss_i.
  - All three are qualified by s1_v.
- icache_poison_o = s1_v & (poison_s1_i | access_fault | page_fault | tlb_miss_i).
- Stage-2 flags: icache_miss = ~icache_data_v_i & ~(any registered fault or miss). Data is enqueued unmodified.
- FIFO:
  - Circular buffer with clog2 pointers wrapping at resp_els_p. Non-power-of-2 depth is supported via explicit compare.
  - Dequeue = resp_v_o & resp_ready_i.
  - Simultaneous enqueue and dequeue keeps the count unchanged, including when full.
  - Overflow is impossible by credit construction. An assertion fires if enqueue occurs while count==resp_els_p without a dequeue.
- Ops arriving in the same cycle as a poison are still accepted; poison affects only stages 1 and 2.
- A fence does not flush the pipeline; in-flight fetches complete.
- Async reset mid-transfer drops all in-flight and queued responses. The first post-reset accept is allowed in the first cycle after deassertion.

Test Plan:
- Reset then single fetch with vaddr 0x80000000, ptag 0x80000, all permissions clear, no translation, data 0x00000013 hit -> resp_v_o high at cycle 3, data 0x13, flags 0000.
- resp_ready_i held 0 with 4 fetches -> credits_o 4→0, cmd_yumi_o low on the 5th fetch. Release ready -> FIFO order preserved, credits return to 4.
- ptag 0x10 -> flags 1000. S-mode with u=1, translation_en=1 -> flags 0100, icache_poison_o=1 in stage 1.
- poison_s1_i on cycle 1 -> no response, credit returns next cycle. poison_s2_i on cycle 2 -> same.
- Depth 3 FIFO, full, with simultaneous enqueue and dequeue -> count stays 3, pointers wrap 2→0 correctly.
- reset_i asserted mid-flight with 2 queued responses -> resp_v_o=0 immediately (asynchronous), credits_o=resp_els_p.
